// File: rtl/cv32e41s_rr_arbiter.sv
// ---------------------------------------------------------------------------
// cv32e41s_rr_arbiter
//
// Registered N-way request arbiter. It shares one downstream consumer between
// up to 32 requesters. Each cycle in which the output register can accept a
// new payload, one requester is selected and granted. Its payload and index
// are then captured into a valid/ready output register.
//
// Build option:
//   CV32E41S_ARB_RR_EN  defined   -> round-robin selection. The rotation
//                                    pointer holds the last winner; index 0
//                                    has first priority after reset.
//                       undefined -> fixed priority. The lowest set request
//                                    index always wins.
//
// Parameters:
//   NUM_REQ  number of requesters (2..32)
//   DATA_W   payload width per requester
//   IDX_W    derived, $clog2(NUM_REQ)
//
// Ports:
//   clk          clock; all state changes on the rising edge
//   rst_n        synchronous active-low reset
//   req_i        per-requester request level
//   data_i       packed payloads; requester k at [k*DATA_W +: DATA_W]
//   gnt_o        one-hot or zero grant. The granted payload is taken this
//                cycle.
//   out_valid_o  output register holds a payload
//   out_ready_i  consumer accepts the output this cycle
//   out_idx_o    index of the requester whose payload is held
//   out_data_o   held payload
// ---------------------------------------------------------------------------
module cv32e41s_rr_arbiter #(
  parameter  int NUM_REQ = 4,
  parameter  int DATA_W  = 32,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*DATA_W-1:0] data_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [IDX_W-1:0]          out_idx_o,
  output logic [DATA_W-1:0]         out_data_o
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]         state;
  logic               take;
  logic               any_req;
  logic               found;
  logic [IDX_W-1:0]   winner;
  logic [NUM_REQ-1:0] gnt;
  logic [DATA_W-1:0]  win_data;
  logic [IDX_W-1:0]   idx_q;
  logic [DATA_W-1:0]  data_q;

  assign any_req = |req_i;

  // The output register can accept a new payload when it is empty, or when
  // its current content leaves on this edge. A handshake and a new capture
  // can therefore share one edge.
  assign take = rst_n && ((state == IDLE) || out_ready_i);

`ifdef CV32E41S_ARB_RR_EN
  logic [IDX_W-1:0]   ptr;
  logic [NUM_REQ-1:0] hi;

  // Requests strictly above the last winner.
  always_comb begin
    hi = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      hi[k] = req_i[k] && (k > 32'(ptr));
    end
  end

  // Lowest set bit of hi. If hi is empty, take the lowest set bit of req_i
  // instead. This covers wrap-around when ptr = NUM_REQ-1.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!found && hi[k]) begin
        winner = IDX_W'(k);
        found  = 1'b1;
      end
    end
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!found && req_i[k]) begin
        winner = IDX_W'(k);
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= IDX_W'(NUM_REQ - 1);
    end else if (take && any_req) begin
      ptr <= winner;
    end
  end
`else
  // Fixed priority: the lowest set request index wins.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!found && req_i[k]) begin
        winner = IDX_W'(k);
        found  = 1'b1;
      end
    end
  end
`endif

  // Payload mux. Its output feeds only the capture register, so data_i has
  // no combinational path to any output.
  always_comb begin
    win_data = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (k == 32'(winner)) begin
        win_data = data_i[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (take && any_req) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        if (k == 32'(winner)) begin
          gnt[k] = 1'b1;
        end
      end
    end
  end

  assign gnt_o = gnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx_q  <= '0;
      data_q <= '0;
    end else if (take) begin
      if (any_req) begin
        state  <= BUSY;
        idx_q  <= winner;
        data_q <= win_data;
      end else begin
        // Either the register was already empty, or the held payload has
        // just been accepted with nothing to replace it.
        state <= IDLE;
      end
    end
  end

  assign out_valid_o = (state == BUSY);
  assign out_idx_o   = idx_q;
  assign out_data_o  = data_q;

endmodule

// File: tb/tb_cv32e41s_rr_arbiter.sv
module tb_cv32e41s_rr_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 32;
  localparam int IDX_W   = $clog2(NUM_REQ);

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req_i;
  logic [NUM_REQ*DATA_W-1:0] data_i;
  logic [NUM_REQ-1:0]        gnt_o;
  logic                      out_valid_o;
  logic                      out_ready_i;
  logic [IDX_W-1:0]          out_idx_o;
  logic [DATA_W-1:0]         out_data_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: content of the output register.
  bit          m_valid = 1'b0;
  int          m_idx   = 0;
  logic [31:0] m_data  = '0;
`ifdef CV32E41S_ARB_RR_EN
  int          m_last  = NUM_REQ - 1;  // most recently served requester
`endif

  always #5 clk = ~clk;

  cv32e41s_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .DATA_W  (DATA_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req_i),
    .data_i      (data_i),
    .gnt_o       (gnt_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_idx_o   (out_idx_o),
    .out_data_o  (out_data_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Winner selection. Round-robin walks the requesters in circular order,
  // starting just after the last one served. Fixed priority picks the lowest
  // requesting index. Returns -1 when nobody requests.
  function automatic int pick(input logic [NUM_REQ-1:0] r);
`ifdef CV32E41S_ARB_RR_EN
    for (int j = 1; j <= NUM_REQ; j++) begin
      int c;
      c = (m_last + j) % NUM_REQ;
      if (r[c]) return c;
    end
`else
    for (int c = 0; c < NUM_REQ; c++) begin
      if (r[c]) return c;
    end
`endif
    return -1;
  endfunction

  // One clock cycle. Inputs are driven just after the rising edge and outputs
  // are checked on the falling edge. The model then advances on the next
  // rising edge.
  task automatic step(input logic r, input logic [NUM_REQ-1:0] rq, input logic rdy,
                      input logic [NUM_REQ*DATA_W-1:0] d, input string tag);
    bit                 take;
    int                 w;
    logic [NUM_REQ-1:0] eg;
    logic [31:0]        one_hot;
    rst_n       = r;
    req_i       = rq;
    out_ready_i = rdy;
    data_i      = d;
    take = r && (!m_valid || rdy);
    w    = pick(rq);
    eg   = '0;
    if (take && w >= 0) begin
      one_hot = 32'd1 << w;
      eg      = one_hot[NUM_REQ-1:0];
    end
    @(negedge clk);
    check({tag, ".gnt"},   64'(gnt_o),       64'(eg));
    check({tag, ".valid"}, 64'(out_valid_o), 64'(m_valid));
    check({tag, ".idx"},   64'(out_idx_o),   64'(m_idx));
    check({tag, ".data"},  64'(out_data_o),  64'(m_data));
    @(posedge clk);
    if (!r) begin
      m_valid = 1'b0;
      m_idx   = 0;
      m_data  = '0;
`ifdef CV32E41S_ARB_RR_EN
      m_last  = NUM_REQ - 1;
`endif
    end else if (take && w >= 0) begin
      m_valid = 1'b1;
      m_idx   = w;
      m_data  = d[w*DATA_W +: DATA_W];
`ifdef CV32E41S_ARB_RR_EN
      m_last  = w;
`endif
    end else if (take) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  logic [NUM_REQ*DATA_W-1:0] fixed_d;
  logic [NUM_REQ*DATA_W-1:0] rnd_d;

  initial begin
    for (int k = 0; k < NUM_REQ; k++) begin
      fixed_d[k*DATA_W +: DATA_W] = 32'hA000_0000 + 32'(k);
    end
    rst_n       = 1'b0;
    req_i       = 4'b1111;
    out_ready_i = 1'b1;
    data_i      = fixed_d;
    @(posedge clk);
    #1;

    // Reset held with every requester active.
    for (int i = 0; i < 3; i++) step(1'b0, 4'b1111, 1'b1, fixed_d, "reset");

    // Streaming with all requesters active and the consumer always ready.
    for (int i = 0; i < 6; i++) step(1'b1, 4'b1111, 1'b1, fixed_d, "stream");
    for (int i = 0; i < 2; i++) step(1'b1, 4'b0000, 1'b1, fixed_d, "drain1");

    // Backpressure: one grant, then the payload is held until ready.
    step(1'b1, 4'b0110, 1'b0, fixed_d, "bp_grant");
    for (int i = 0; i < 3; i++) step(1'b1, 4'b0100, 1'b0, fixed_d, "bp_hold");
    step(1'b1, 4'b0100, 1'b1, fixed_d, "bp_release");
    for (int i = 0; i < 2; i++) step(1'b1, 4'b0000, 1'b1, fixed_d, "drain2");

    // Wrap-around after a grant to the highest index.
    step(1'b1, 4'b1000, 1'b1, fixed_d, "wrap_hi");
    for (int i = 0; i < 3; i++) step(1'b1, 4'b1001, 1'b1, fixed_d, "wrap");
    for (int i = 0; i < 2; i++) step(1'b1, 4'b0000, 1'b1, fixed_d, "drain3");

    // A single request, then return to idle.
    step(1'b1, 4'b0100, 1'b1, fixed_d, "single");
    for (int i = 0; i < 2; i++) step(1'b1, 4'b0000, 1'b1, fixed_d, "idle_ret");

    // Reset while the output is held under backpressure.
    step(1'b1, 4'b0010, 1'b0, fixed_d, "busy_pre");
    step(1'b1, 4'b0000, 1'b0, fixed_d, "busy_hold");
    step(1'b0, 4'b0010, 1'b0, fixed_d, "busy_rst");
    step(1'b1, 4'b0000, 1'b1, fixed_d, "after_rst");

    // Fixed high-priority pair.
    for (int i = 0; i < 3; i++) step(1'b1, 4'b1100, 1'b1, fixed_d, "pair");
    step(1'b1, 4'b0000, 1'b1, fixed_d, "drain4");

    // Randomized traffic with random backpressure and occasional resets.
    for (int i = 0; i < 600; i++) begin
      logic [NUM_REQ-1:0] rq;
      logic               rdy;
      logic               r;
      for (int k = 0; k < NUM_REQ; k++) rnd_d[k*DATA_W +: DATA_W] = $urandom;
      rq  = NUM_REQ'($urandom);
      rdy = ($urandom_range(0, 3) != 0);
      r   = ($urandom_range(0, 49) != 0);
      step(r, rq, rdy, rnd_d, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
